// File: rtl/i2c_tx_queue.sv
// Elastic FIFO between the CPU ready/valid transmit port and the i2c master wr/busy handshake.
// Define I2C_TX_QUEUE_STATS_EN to add the hwm / words_sent / timeouts statistics outputs.
module i2c_tx_queue #(
  parameter int DEPTH    = 16,
  parameter int ACK_WAIT = 8,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [8:0]    in_data,
  output logic          in_ready,
  output logic          i2c_wr,
  output logic [8:0]    i2c_data,
  input  logic          i2c_busy,
  output logic [AW:0]   level,
  output logic          ack_timeout
`ifdef I2C_TX_QUEUE_STATS_EN
  ,
  output logic [AW:0]   hwm,
  output logic [15:0]   words_sent,
  output logic [7:0]    timeouts
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, DONE} state_t;

  state_t          state, state_nxt;
  logic [8:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [7:0]      timer;
  logic            push, pop;
  logic            timer_clr, timer_inc, timeout_nxt;

  assign in_ready = (level != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (level != '0) && !i2c_busy;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt   = state;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE:  if (pop) state_nxt = ISSUE;
      ISSUE: begin
        timer_clr = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        if (i2c_busy) begin
          state_nxt = DONE;
        end else if (timer == 8'(ACK_WAIT - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_inc = 1'b1;
        end
      end
      DONE:    if (!i2c_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: storage array has no reset; level and the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      i2c_wr      <= 1'b0;
      i2c_data    <= '0;
      ack_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      i2c_wr      <= pop;
      ack_timeout <= timeout_nxt;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 8'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        i2c_data <= mem[rd_ptr];
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef I2C_TX_QUEUE_STATS_EN
  // level never exceeds DEPTH, so the high-water mark saturates by construction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm        <= '0;
      words_sent <= '0;
      timeouts   <= '0;
    end else begin
      if (level > hwm) hwm <= level;
      if (pop) words_sent <= words_sent + 16'd1;
      if (timeout_nxt && timeouts != 8'hFF) timeouts <= timeouts + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_tx_queue.sv
// Scoreboard bench for i2c_tx_queue: stimulus pushes expected words, a negedge monitor checks each wr strobe.
module tb_i2c_tx_queue;

  localparam int DEPTH    = 16;
  localparam int ACK_WAIT = 8;
  localparam int AW       = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [8:0]    in_data;
  logic          in_ready;
  logic          i2c_wr;
  logic [8:0]    i2c_data;
  logic          i2c_busy;
  logic [AW:0]   level;
  logic          ack_timeout;
`ifdef I2C_TX_QUEUE_STATS_EN
  logic [AW:0]   hwm;
  logic [15:0]   words_sent;
  logic [7:0]    timeouts;
`endif

  int         vectors     = 0;
  int         miscompares = 0;
  int         wr_count    = 0;
  int         to_count    = 0;
  logic [8:0] exp_q[$];
  logic       force_busy;
  logic       model_busy;
  logic       respond;
  int         hold;

  assign i2c_busy = force_busy | model_busy;

  always #5 clk = ~clk;

  i2c_tx_queue #(.DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .i2c_wr      (i2c_wr),
    .i2c_data    (i2c_data),
    .i2c_busy    (i2c_busy),
    .level       (level),
    .ack_timeout (ack_timeout)
`ifdef I2C_TX_QUEUE_STATS_EN
    ,
    .hwm         (hwm),
    .words_sent  (words_sent),
    .timeouts    (timeouts)
`endif
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Master model: busy rises one cycle after a wr strobe and holds for 'hold' cycles.
  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_wr && respond) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (hold) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  // Monitor: every wr strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (level > DEPTH) begin
        miscompares++;
        $display("FAIL level_bound: got %0d, expected <= %0d", level, DEPTH);
      end
      if (ack_timeout) to_count++;
      if (i2c_wr) begin
        wr_count++;
        if (exp_q.size() == 0) bound_fail("unexpected_wr");
        else check("wr_data", 32'(i2c_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic push(input logic [8:0] d);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      bound_fail("push_wait");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(d);
      #1 in_valid = 1'b0;
    end
  endtask

  // Waits until the queue, scoreboard and master have been quiet for 12 consecutive cycles.
  task automatic wait_drain(input string name);
    int quiet = 0;
    int n     = 0;
    while (quiet < 12 && n < 5000) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0 && level == 0 && !i2c_busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 12) bound_fail(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_to;
    int wr_base;
    int to_base;

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    force_busy = 1'b0;
    respond    = 1'b1;
    hold       = 20;

    #3;
    check("rst_level",    32'(level),       32'd0);
    check("rst_in_ready", 32'(in_ready),    32'd1);
    check("rst_wr",       32'(i2c_wr),      32'd0);
    check("rst_data",     32'(i2c_data),    32'd0);
    check("rst_timeout",  32'(ack_timeout), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single word, 20-cycle busy: wr exactly 2 cycles after acceptance.
    push(9'h155);
    @(negedge clk);
    check("lat_wr_c1",   32'(i2c_wr),   32'd0);
    check("lat_ready_c1", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("lat_wr_c2",   32'(i2c_wr),   32'd1);
    check("lat_data_c2", 32'(i2c_data), 32'h155);
    check("lat_ready_c2", 32'(in_ready), 32'd1);
    wait_drain("drain_single");
    check("single_level",   32'(level),    32'd0);
    check("single_wr_cnt",  32'(wr_count), 32'd1);
    check("single_no_to",   32'(to_count), 32'd0);

    // Fill to DEPTH while the master is busy, then a held 17th word.
    hold       = 3;
    force_busy = 1'b1;
    wr_base    = wr_count;
    for (int i = 0; i < DEPTH; i++) push(9'(i));
    @(negedge clk);
    check("full_level", 32'(level),    32'd16);
    check("full_ready", 32'(in_ready), 32'd0);
    fork
      push(9'h1AB);
      begin
        repeat (5) @(negedge clk);
        check("held_level", 32'(level),    32'd16);
        check("held_ready", 32'(in_ready), 32'd0);
        check("held_no_wr", 32'(wr_count), 32'(wr_base));
        force_busy = 1'b0;
      end
    join
    wait_drain("drain_full");
    check("full_wr_cnt", 32'(wr_count - wr_base), 32'd17);

    // Master never answers: timeout 8 cycles after ACK entry, then normal issue.
    respond = 1'b0;
    wr_base = wr_count;
    to_base = to_count;
    push(9'h0AA);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i2c_wr && n < 10);
    if (!i2c_wr) bound_fail("to_wr_wait");
    first_to = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (ack_timeout && first_to == 0) first_to = k;
    end
    check("to_delay",  32'(first_to), 32'(ACK_WAIT + 1));
    check("to_pulses", 32'(to_count - to_base), 32'd1);
    respond = 1'b1;
    push(9'h0C3);
    wait_drain("drain_timeout");
    check("to_wr_cnt", 32'(wr_count - wr_base), 32'd2);
    check("to_total",  32'(to_count - to_base), 32'd1);

    // Streaming 0..99 with the master draining.
    hold    = 2;
    wr_base = wr_count;
    for (int i = 0; i < 100; i++) push(9'(i));
    wait_drain("drain_stream");
    check("stream_wr_cnt", 32'(wr_count - wr_base), 32'd100);
    check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef I2C_TX_QUEUE_STATS_EN
    check("stats_hwm",        32'(hwm),        32'd16);
    check("stats_timeouts",   32'(timeouts),   32'd1);
    check("stats_words_sent", 32'(words_sent), 32'(wr_count));
`endif

    // Reset while the master is busy (DONE) with 5 words still queued.
    hold = 30;
    for (int i = 0; i < 6; i++) push(9'h100 + 9'(i));
    repeat (5) @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_level", 32'(level),    32'd0);
    check("arst_wr",    32'(i2c_wr),   32'd0);
    check("arst_data",  32'(i2c_data), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
`ifdef I2C_TX_QUEUE_STATS_EN
    check("arst_hwm",        32'(hwm),        32'd0);
    check("arst_words_sent", 32'(words_sent), 32'd0);
    check("arst_timeouts",   32'(timeouts),   32'd0);
`endif
    exp_q.delete();
    wr_base = wr_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_no_wr", 32'(wr_count - wr_base), 32'd0);
    push(9'h077);
    wait_drain("drain_post_rst");
    check("post_rst_wr", 32'(wr_count - wr_base), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
